wb_node_arbiter: RTL and testbench
==================================

// Module: wb_node_arbiter
// PURPOSE
//  Two-master, one-slave Wishbone (classic, non-pipelined) arbiter in the user project area.
//  It shares the user-project register/memory slave between two masters:
//    - Master 0: the Caravel management SoC (wbs_* port).
//    - Master 1: the node's internal requester.
//  Arbitration is round-robin. Grant is held for a whole bus cycle. A bus-watchdog returns err to a stalled master.
// PARAMETERS
//  AW       32   address width
//  DW       32   data width; sel width is DW/8
//  TIMEOUT  255  max cycles stb may wait for ack before err; must be >=1, counter is $clog2(TIMEOUT+1) bits
// PORTS
//  wb_clk_i     in   1      bus clock
//  wb_rst_i     in   1      asynchronous active-high reset
//  m0_cyc_i     in   1      master 0 cycle
//  m0_stb_i     in   1      master 0 strobe
//  m0_we_i      in   1      master 0 write enable
//  m0_sel_i     in   DW/8   master 0 byte selects
//  m0_adr_i     in   AW     master 0 address
//  m0_dat_i     in   DW     master 0 write data
//  m0_dat_o     out  DW     master 0 read data
//  m0_ack_o     out  1      master 0 acknowledge
//  m0_err_o     out  1      master 0 watchdog error
//  m1_*                     same set as m0_*, for master 1
//  s_cyc_o      out  1      slave cycle
//  s_stb_o      out  1      slave strobe
//  s_we_o       out  1      slave write enable
//  s_sel_o      out  DW/8   slave byte selects
//  s_adr_o      out  AW     slave address
//  s_dat_o      out  DW     slave write data
//  s_dat_i      in   DW     slave read data
//  s_ack_i      in   1      slave acknowledge
//  gnt_o        out  2      one-hot current grant {m1,m0}; 2'b00 when idle
// BEHAVIOUR
//  - Reset (async, wb_rst_i=1):
//    - state=IDLE, last=1 (so m0 wins the first tie), watchdog=0.
//    - All outputs 0 while reset is asserted and on release.
//    - Reset mid-transfer drops s_cyc_o/s_stb_o immediately. No ack or err is issued to the aborted master.
//  - FSM states IDLE, GNT0, GNT1. The grant is registered.
//    - IDLE:
//      - only m0_cyc_i -> GNT0.
//      - only m1_cyc_i -> GNT1.
//      - both -> the master != last.
//      - neither -> stay IDLE.
//    - GNTn: stay while mn_cyc_i=1. When mn_cyc_i=0 -> IDLE and last<=n.
//    - Every release passes through one IDLE cycle (turnaround). No back-to-back grant switch.
//  - Latency: a request made in IDLE reaches s_cyc_o/s_stb_o on the cycle after cyc is sampled. Total 1-cycle arbitration cost.
//  - Datapath, combinational from the registered grant:
//    - In GNTn, s_* = mn_* and mn_ack_o = s_ack_i.
//    - The non-granted master's ack/err = 0.
//    - In IDLE, s_cyc_o = s_stb_o = 0. s_adr/dat/sel/we are don't-care; drive 0.
//  - m0_dat_o = m1_dat_o = s_dat_i, unqualified; masters qualify with ack.
//  - Watchdog:
//    - Counts cycles with s_stb_o=1 and s_ack_i=0. Clears on ack, on stb low and in IDLE.
//    - When count==TIMEOUT and no ack, mn_err_o=1 for exactly one cycle.
//    - s_stb_o is forced 0 that cycle and the counter clears. The grant stays until the master drops cyc.
//    - ack and err are never both 1. If ack arrives on the timeout cycle, ack wins and no err is issued.
//  - Simultaneous events:
//    - Release of GNTn and a request from the other master in the same cycle: IDLE first, other master granted next.
//    - A master re-asserting cyc during its own turnaround loses to a waiting peer, due to round-robin.
// TESTING
//  - Reset then single m0 read, slave acks 2 cycles after stb:
//    -> gnt_o=01 one cycle after m0_cyc, m0_ack_o high one cycle, m0_dat_o=slave data 0xDEADBEEF.
//  - m0 and m1 request together from reset:
//    -> m0 granted first, then IDLE one cycle, then m1. Repeat both -> m0 next (strict alternation).
//  - m1 holds cyc for a 4-beat burst of stb/ack while m0 requests:
//    -> m0 never sees ack, and gnt_o stays 10 until m1_cyc drops.
//  - Slave never acks, TIMEOUT=8:
//    -> m0_err_o pulses exactly once on the 8th stalled cycle, s_stb_o low that cycle, no m0_ack_o.
//  - Slave acks exactly on the timeout cycle -> ack delivered, err stays 0.
//  - wb_rst_i asserted mid-write:
//    -> s_cyc_o/s_stb_o drop without a clock edge, gnt_o=00. After release, m0 wins a tie.

Source files
------------

// File: rtl/wb_node_arbiter.sv
// Round-robin 2-master/1-slave Wishbone classic arbiter; registered grant, 1-cycle arbitration plus 1 idle turnaround.
// Slave stalls pass straight through; a stalled strobe is errored back to its master after TIMEOUT cycles.
module wb_node_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic [AW-1:0]     m0_adr_i,
    input  logic [DW-1:0]     m0_dat_i,
    output logic [DW-1:0]     m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic [AW-1:0]     m1_adr_i,
    input  logic [DW-1:0]     m1_dat_i,
    output logic [DW-1:0]     m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [DW/8-1:0]   s_sel_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    input  logic [DW-1:0]     s_dat_i,
    input  logic              s_ack_i,
    output logic [1:0]        gnt_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t        r_state;
    logic [1:0]    r_gnt;
    logic          r_last;
    logic [CW-1:0] r_wdog;

    logic w_act;
    logic w_sel1;
    logic w_cyc;
    logic w_stb;
    logic w_to;

    assign w_act  = r_gnt[0] | r_gnt[1];
    assign w_sel1 = r_gnt[1];
    assign w_cyc  = w_sel1 ? m1_cyc_i : m0_cyc_i;
    assign w_stb  = w_act & (w_sel1 ? m1_stb_i : m0_stb_i);
    // The timeout cycle is itself the last stalled cycle; a same-cycle ack cancels it.
    assign w_to   = w_stb & ~s_ack_i & (r_wdog == CW'(TIMEOUT - 1));

    assign s_cyc_o = w_act & w_cyc;
    assign s_stb_o = w_stb & ~w_to;
    assign s_we_o  = w_act & (w_sel1 ? m1_we_i : m0_we_i);
    assign s_sel_o = w_act ? (w_sel1 ? m1_sel_i : m0_sel_i) : '0;
    assign s_adr_o = w_act ? (w_sel1 ? m1_adr_i : m0_adr_i) : '0;
    assign s_dat_o = w_act ? (w_sel1 ? m1_dat_i : m0_dat_i) : '0;

    assign m0_ack_o = r_gnt[0] & s_ack_i;
    assign m0_err_o = r_gnt[0] & w_to;
    assign m1_ack_o = r_gnt[1] & s_ack_i;
    assign m1_err_o = r_gnt[1] & w_to;

    // Read data is shared and unqualified; it is only held at zero during reset.
    assign m0_dat_o = wb_rst_i ? '0 : s_dat_i;
    assign m1_dat_o = wb_rst_i ? '0 : s_dat_i;

    assign gnt_o = r_gnt;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_gnt   <= 2'b00;
            r_last  <= 1'b1;
            r_wdog  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_wdog <= '0;
                    if (m0_cyc_i && (!m1_cyc_i || r_last)) begin
                        r_state <= GNT0;
                        r_gnt   <= 2'b01;
                    end else if (m1_cyc_i) begin
                        r_state <= GNT1;
                        r_gnt   <= 2'b10;
                    end
                end
                GNT0, GNT1: begin
                    if (!w_cyc) begin
                        r_state <= IDLE;
                        r_gnt   <= 2'b00;
                        r_last  <= (r_state == GNT1);
                        r_wdog  <= '0;
                    end else if (w_stb && !s_ack_i && !w_to) begin
                        r_wdog <= r_wdog + CW'(1);
                    end else begin
                        r_wdog <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= 2'b00;
                    r_wdog  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_node_arbiter.sv
// Bench for wb_node_arbiter: directed scenarios plus random traffic against an integer-level ownership model.
module tb_wb_node_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic [1:0]    cyc = '0;
    logic [1:0]    stb = '0;
    logic [1:0]    we  = '0;
    logic [SW-1:0] sel  [2];
    logic [AW-1:0] adr  [2];
    logic [DW-1:0] wdat [2];
    logic [DW-1:0] m0_dat_o, m1_dat_o, s_dat_o;
    logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [SW-1:0] s_sel_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_i = 32'hA5A5_A5A5;
    logic          s_ack_i = 1'b0;
    logic [1:0]    gnt_o;

    int n_vec = 0;
    int n_bad = 0;
    // Model: own = index of master holding the bus (-1 none), last = last released owner.
    int own   = -1;
    int last  = 1;
    int stall = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_node_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
        .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
        .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .gnt_o(gnt_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        own   = -1;
        last  = 1;
        stall = 0;
    endtask

    // Called at a negedge with inputs already driven: checks this cycle, advances the model, returns at next negedge.
    task automatic step();
        logic [8:0]    ce;
        logic [8:0]    co;
        logic [AW-1:0] ae;
        logic [DW-1:0] de;
        logic [SW-1:0] se;
        logic          ms;
        logic          to;
        ce = '0; ae = '0; de = '0; se = '0; ms = 1'b0; to = 1'b0;
        #1;
        if (own >= 0) begin
            ms = stb[own];
            to = ms && !s_ack_i && (stall == TO - 1);
            ce = {own == 1, own == 0, cyc[own], ms && !to, we[own],
                  own == 0 && s_ack_i, own == 0 && to, own == 1 && s_ack_i, own == 1 && to};
            ae = adr[own];
            de = wdat[own];
            se = sel[own];
        end
        co = {gnt_o, s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o};
        check("ctl", 64'(co), 64'(ce));
        check("s_adr", 64'(s_adr_o), 64'(ae));
        check("s_dat", 64'(s_dat_o), 64'(de));
        check("s_sel", 64'(s_sel_o), 64'(se));
        check("m_dat", {m1_dat_o, m0_dat_o}, {s_dat_i, s_dat_i});
        if (own < 0) begin
            stall = 0;
            if (cyc[0] && cyc[1]) own = 1 - last;
            else if (cyc[0])      own = 0;
            else if (cyc[1])      own = 1;
        end else if (!cyc[own]) begin
            last  = own;
            own   = -1;
            stall = 0;
        end else if (ms && !s_ack_i && !to) begin
            stall++;
        end else begin
            stall = 0;
        end
        @(negedge wb_clk_i);
    endtask

    task automatic all_idle();
        cyc = '0; stb = '0; we = '0; s_ack_i = 1'b0;
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            sel[m]  = SW'(4'hF);
            adr[m]  = AW'(32'h100 + 32'h10 * m);
            wdat[m] = DW'(32'h1111_0000 + m);
        end
        #2;
        check("rst_ctl", 64'({gnt_o, s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 64'd0);
        check("rst_adr", 64'(s_adr_o), 64'd0);
        check("rst_mdat", {m1_dat_o, m0_dat_o}, 64'd0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        model_reset();

        // Single m0 read, slave acks two cycles after the strobe.
        cyc[0] = 1'b1; stb[0] = 1'b1;
        step();
        #1 check("t1_gnt", 64'(gnt_o), 64'h1);
        check("t1_stb", 64'(s_stb_o), 64'h1);
        step();
        step();
        s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        #1 check("t1_ack", 64'(m0_ack_o), 64'h1);
        check("t1_rdat", 64'(m0_dat_o), 64'hDEAD_BEEF);
        step();
        all_idle();
        step();
        step();

        // Simultaneous requests from reset alternate strictly.
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        model_reset();
        cyc = 2'b11;
        step();
        #1 check("t2_first", 64'(gnt_o), 64'h1);
        step();
        cyc = 2'b10;
        step();
        cyc = 2'b11;
        #1 check("t2_turn", 64'(gnt_o), 64'h0);
        step();
        #1 check("t2_second", 64'(gnt_o), 64'h2);
        step();
        cyc = 2'b01;
        step();
        cyc = 2'b11;
        step();
        #1 check("t2_third", 64'(gnt_o), 64'h1);
        step();
        all_idle();
        step();
        step();

        // m1 burst of four beats while m0 waits.
        cyc = 2'b10;
        step();
        cyc = 2'b11;
        for (int b = 0; b < 4; b++) begin
            stb[1] = 1'b1; s_ack_i = 1'b0;
            #1 check("t3_gnt", 64'(gnt_o), 64'h2);
            step();
            s_ack_i = 1'b1; s_dat_i = DW'($urandom);
            #1 check("t3_m0ack", 64'({m0_ack_o, m1_ack_o}), 64'h1);
            step();
        end
        cyc[1] = 1'b0; stb[1] = 1'b0; s_ack_i = 1'b0;
        step();
        #1 check("t3_turn", 64'(gnt_o), 64'h0);
        step();

        // Slave never acks: err on the 8th stalled cycle only.
        stb[0] = 1'b1;
        #1 check("t4_gnt", 64'(gnt_o), 64'h1);
        for (int k = 1; k <= TO; k++) begin
            #1 check("t4_err", 64'({m0_err_o, s_stb_o, m0_ack_o}), (k == TO) ? 64'h4 : 64'h2);
            step();
        end
        all_idle();
        step();
        step();

        // Ack landing on the timeout cycle wins over err.
        cyc[0] = 1'b1; stb[0] = 1'b1;
        step();
        for (int k = 1; k < TO; k++) step();
        s_ack_i = 1'b1;
        #1 check("t5_ack", 64'({m0_ack_o, m0_err_o, s_stb_o}), 64'h5);
        step();
        all_idle();
        step();
        step();

        // Reset asserted mid-write drops the bus without a clock edge.
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
        step();
        step();
        #2 wb_rst_i = 1'b1;
        #1 check("t6_drop", 64'({gnt_o, s_cyc_o, s_stb_o, m1_ack_o, m1_err_o}), 64'h0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        model_reset();
        cyc = 2'b11;
        step();
        #1 check("t6_tie", 64'(gnt_o), 64'h1);
        step();
        all_idle();
        step();

        // Random traffic; long ack-less windows let the watchdog fire.
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(7) == 0) cyc[m] = ~cyc[m];
                stb[m]  = ((c % 128) < 48) ? ($urandom_range(15) != 0) : ($urandom_range(3) != 0);
                we[m]   = 1'($urandom);
                sel[m]  = SW'($urandom);
                adr[m]  = AW'($urandom);
                wdat[m] = DW'($urandom);
            end
            s_ack_i = ((c % 128) < 48) ? 1'b0 : ($urandom_range(2) == 0);
            s_dat_i = DW'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
